// File: rtl/barrel_pool_if.sv
// Spawn/clear handshake and packed per-slot status between the barrel pool
// and whatever game logic drives it.
interface barrel_pool_if #(
    parameter int N_BARRELS = 4
);
    logic                     spawn;
    logic                     clear_all;
    logic                     spawn_ready;
    logic [N_BARRELS-1:0]     active;
    logic [N_BARRELS-1:0]     done;
    logic [11*N_BARRELS-1:0]  xpos;
    logic [11*N_BARRELS-1:0]  ypos;

    modport master (output spawn, clear_all,
                    input  spawn_ready, active, done, xpos, ypos);
    modport slave  (input  spawn, clear_all,
                    output spawn_ready, active, done, xpos, ypos);
endinterface

// File: rtl/barrel_pool.sv
// Pool of independent barrels: each slot rolls along a platform, falls with
// accelerating steps to the next level, and retires after the last level.
module barrel_slot #(
    parameter int SPAWN_X     = 128,
    parameter int X_MIN       = 64,
    parameter int X_MAX       = 960,
    parameter int Y_TOP       = 175,
    parameter int LEVEL_PITCH = 128,
    parameter int N_LEVELS    = 4,
    parameter int MOVE_DIV    = 4095,
    parameter int FALL_DIV    = 8191
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        start,
    output logic        busy,
    output logic        idle,
    output logic        done,
    output logic [10:0] x_o,
    output logic [10:0] y_o
);
    typedef enum logic [1:0] {IDLE, ROLL, FALL} state_t;

    state_t      state, state_n;
    logic [20:0] cnt, cnt_n;
    logic [3:0]  vel, vel_n;
    logic [2:0]  lvl, lvl_n;
    logic [11:0] x, x_n, y, y_n;
    logic        done_q, done_n;
    logic [11:0] land, y_step;
    logic        at_edge;

    assign land    = 12'(Y_TOP) + ({9'd0, lvl} + 12'd1) * 12'(LEVEL_PITCH);
    assign y_step  = y + {8'd0, vel};
    // Even levels roll right toward X_MAX, odd levels left toward X_MIN.
    assign at_edge = lvl[0] ? (x == 12'(X_MIN)) : (x == 12'(X_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            vel    <= '0;
            lvl    <= '0;
            x      <= 12'(SPAWN_X);
            y      <= 12'(Y_TOP);
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            vel    <= vel_n;
            lvl    <= lvl_n;
            x      <= x_n;
            y      <= y_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vel_n   = vel;
        lvl_n   = lvl;
        x_n     = x;
        y_n     = y;
        done_n  = 1'b0;
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            vel_n   = '0;
            lvl_n   = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n = ROLL;
                    cnt_n   = '0;
                    vel_n   = '0;
                    lvl_n   = '0;
                    x_n     = 12'(SPAWN_X);
                    y_n     = 12'(Y_TOP);
                end
                ROLL: if (at_edge) begin
                    state_n = FALL;
                    cnt_n   = '0;
                    vel_n   = '0;
                end else if (cnt == 21'(MOVE_DIV)) begin
                    cnt_n = '0;
                    x_n   = lvl[0] ? x - 12'd1 : x + 12'd1;
                end else begin
                    cnt_n = cnt + 21'd1;
                end
                FALL: if (cnt == 21'(FALL_DIV)) begin
                    cnt_n = '0;
                    vel_n = (vel == 4'd15) ? vel : vel + 4'd1;
                    if (y_step >= land) begin
                        y_n = land;
                        if (lvl == 3'(N_LEVELS - 1)) begin
                            state_n = IDLE;
                            lvl_n   = '0;
                            vel_n   = '0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ROLL;
                            lvl_n   = lvl + 3'd1;
                            vel_n   = '0;
                        end
                    end else begin
                        y_n = y_step;
                    end
                end else begin
                    cnt_n = cnt + 21'd1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign idle = (state == IDLE);
    assign busy = ~idle;
    assign done = done_q;
    assign x_o  = idle ? 11'(SPAWN_X) : x[10:0];
    assign y_o  = idle ? 11'(Y_TOP)   : y[10:0];
endmodule

module barrel_pool #(
    parameter int N_BARRELS   = 4,
    parameter int SPAWN_X     = 128,
    parameter int X_MIN       = 64,
    parameter int X_MAX       = 960,
    parameter int Y_TOP       = 175,
    parameter int LEVEL_PITCH = 128,
    parameter int N_LEVELS    = 4,
    parameter int MOVE_DIV    = 4095,
    parameter int FALL_DIV    = 8191
) (
    input  logic         clk,
    input  logic         rst,
    barrel_pool_if.slave bus
);
    logic [N_BARRELS-1:0] idle_vec, grant, start;

    // Isolate the lowest set bit: the lowest-index IDLE slot wins the spawn.
    assign grant           = idle_vec & (~idle_vec + N_BARRELS'(1));
    assign start           = (bus.spawn && !bus.clear_all) ? grant : '0;
    assign bus.spawn_ready = |idle_vec;

    for (genvar i = 0; i < N_BARRELS; i++) begin : g_slot
        barrel_slot #(
            .SPAWN_X(SPAWN_X), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_TOP(Y_TOP),
            .LEVEL_PITCH(LEVEL_PITCH), .N_LEVELS(N_LEVELS),
            .MOVE_DIV(MOVE_DIV), .FALL_DIV(FALL_DIV)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .clear (bus.clear_all),
            .start (start[i]),
            .busy  (bus.active[i]),
            .idle  (idle_vec[i]),
            .done  (bus.done[i]),
            .x_o   (bus.xpos[11*i +: 11]),
            .y_o   (bus.ypos[11*i +: 11])
        );
    end
endmodule

// File: tb/tb_barrel_pool.sv
// Directed bench for barrel_pool with a small two-slot, two-level playfield.
module tb_barrel_pool;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    barrel_pool_if #(.N_BARRELS(2)) bus ();

    barrel_pool #(
        .N_BARRELS(2), .SPAWN_X(16), .X_MIN(0), .X_MAX(20), .Y_TOP(10),
        .LEVEL_PITCH(8), .N_LEVELS(2), .MOVE_DIV(1), .FALL_DIV(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [10:0] x0, x1, y0, y1;
    assign x0 = bus.xpos[10:0];
    assign x1 = bus.xpos[21:11];
    assign y0 = bus.ypos[10:0];
    assign y1 = bus.ypos[21:11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int yexp[5] = '{10, 11, 13, 16, 18};
        int yexp2[4] = '{18, 19, 21, 24};

        rst = 1'b1;
        bus.spawn = 1'b0;
        bus.clear_all = 1'b0;
        tick(); tick();
        chk("rst_active", int'(bus.active), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ready", int'(bus.spawn_ready), 1);
        chk("rst_x0", int'(x0), 16);
        chk("rst_x1", int'(x1), 16);
        chk("rst_y0", int'(y0), 10);
        chk("rst_y1", int'(y1), 10);
        rst = 1'b0;

        // single spawn -> slot 0 rolls right one px every 2 clocks
        bus.spawn = 1'b1;
        tick();                                  // E0
        bus.spawn = 1'b0;
        chk("spawn_active", int'(bus.active), 1);
        chk("spawn_ready", int'(bus.spawn_ready), 1);
        chk("spawn_x0", int'(x0), 16);
        for (int k = 1; k <= 4; k++) begin
            tick(); tick();                      // E2k
            chk("roll_x0", int'(x0), 16 + k);
        end
        tick();                                  // E9: FALL
        chk("fall_x0", int'(x0), 20);
        chk("fall_y0", int'(y0), 10);
        chk("fall_active", int'(bus.active), 1);
        for (int k = 0; k < 5; k++) begin
            tick(); tick();                      // E11..E19
            chk("fall1_y0", int'(y0), yexp[k]);
            chk("fall1_x0", int'(x0), 20);
        end
        tick(); tick();                          // E21: rolling left on level 1
        chk("roll1_x0", int'(x0), 19);

        // three spawn cycles: slot 1 taken, the rest dropped
        bus.spawn = 1'b1;
        tick();                                  // E22
        chk("spawn2_active", int'(bus.active), 3);
        chk("spawn2_ready", int'(bus.spawn_ready), 0);
        chk("spawn2_x1", int'(x1), 16);
        tick(); tick();                          // E24
        bus.spawn = 1'b0;
        chk("spawn3_active", int'(bus.active), 3);
        chk("spawn3_ready", int'(bus.spawn_ready), 0);

        repeat (35) tick();                      // E59
        chk("edge_x0", int'(x0), 0);
        tick();                                  // E60: FALL on last level
        chk("fall2_x0", int'(x0), 0);
        chk("fall2_y0", int'(y0), 18);
        for (int k = 0; k < 4; k++) begin
            tick(); tick();                      // E62..E68
            chk("fall2_y0", int'(y0), yexp2[k]);
            chk("fall2_done", int'(bus.done), 0);
        end
        tick(); tick();                          // E70: lands at 26 and retires
        chk("retire_done", int'(bus.done), 1);
        chk("retire_active", int'(bus.active), 2);
        chk("retire_ready", int'(bus.spawn_ready), 1);
        chk("retire_y0", int'(y0), 10);
        chk("retire_x0", int'(x0), 16);
        tick();
        chk("retire_done_pulse", int'(bus.done), 0);
        chk("retire_active2", int'(bus.active), 2);

        // clear_all with spawn during slot 0 FALL
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus.spawn = 1'b1;
        tick();                                  // E0
        bus.spawn = 1'b0;
        repeat (12) tick();                      // E12
        chk("pre_clear_active", int'(bus.active), 1);
        chk("pre_clear_x0", int'(x0), 20);
        bus.clear_all = 1'b1;
        bus.spawn = 1'b1;
        tick();
        bus.clear_all = 1'b0;
        bus.spawn = 1'b0;
        chk("clear_active", int'(bus.active), 0);
        chk("clear_done", int'(bus.done), 0);
        chk("clear_ready", int'(bus.spawn_ready), 1);
        chk("clear_y0", int'(y0), 10);
        tick();
        chk("clear_active2", int'(bus.active), 0);
        chk("clear_done2", int'(bus.done), 0);

        // reset mid-roll aborts with no done pulse and overrides spawn
        bus.spawn = 1'b1;
        tick();
        bus.spawn = 1'b0;
        repeat (3) tick();
        chk("midroll_x0", int'(x0), 17);
        rst = 1'b1;
        bus.spawn = 1'b1;
        tick();
        chk("midrst_active", int'(bus.active), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_x0", int'(x0), 16);
        rst = 1'b0;
        bus.spawn = 1'b0;
        tick();
        chk("postrst_active", int'(bus.active), 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
